// File: rtl/branch_ctrl.sv
// branch_ctrl: branch resolution and program counter for the zepto 16-bit core.
// Latches comparator flags, evaluates branch conditions against latched or
// bypassed flags, owns the PC, and raises flush for a fixed number of
// non-stalled cycles after every taken branch.
module branch_ctrl #(
  parameter int              PC_W         = 16,
  parameter logic [PC_W-1:0] RESET_PC     = 16'h0000,
  parameter int              FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flag_we,
  input  logic            eq,
  input  logic            neq,
  input  logic            geq,
  input  logic            l,
  input  logic            br_valid,
  input  logic [2:0]      br_cond,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      flags,
  output logic            taken,
  output logic            flush,
  output logic            busy
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t          state_reg, state_next;
  logic [PC_W-1:0] pc_reg, pc_next;
  logic [3:0]      flags_reg, flags_next;
  logic [3:0]      cnt_reg, cnt_next;
  logic            taken_reg, taken_next;

  logic [3:0]      cmp_flags;
  logic [3:0]      eff_flags;
  logic            eff_eq, eff_neq, eff_geq, eff_l, eff_is_eq;
  logic            cond_true;

  assign cmp_flags = {eq, neq, geq, l};

  // Same-cycle compare and branch use the comparator output directly.
  assign eff_flags = flag_we ? cmp_flags : flags_reg;
  assign eff_eq    = eff_flags[3];
  assign eff_neq   = eff_flags[2];
  assign eff_geq   = eff_flags[1];
  assign eff_l     = eff_flags[0];
  // An inconsistent eq=neq=1 vector must never resolve as equal.
  assign eff_is_eq = eff_eq & ~eff_neq;

  // Condition-code decode against the effective flags.
  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      3'b000:  cond_true = 1'b0;
      3'b001:  cond_true = 1'b1;
      3'b010:  cond_true = eff_is_eq;
      3'b011:  cond_true = eff_neq;
      3'b100:  cond_true = eff_geq;
      3'b101:  cond_true = eff_l;
      3'b110:  cond_true = eff_l | eff_is_eq;
      3'b111:  cond_true = eff_geq & eff_neq;
      default: cond_true = 1'b0;
    endcase
  end

  // Next-state logic: stall holds everything and only drops the taken pulse.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    flags_next = flags_reg;
    cnt_next   = cnt_reg;
    taken_next = 1'b0;
    if (!stall) begin
      case (state_reg)
        RUN: begin
          if (flag_we) begin
            flags_next = cmp_flags;
          end
          if (br_valid && cond_true) begin
            pc_next    = br_target;
            taken_next = 1'b1;
            cnt_next   = FLUSH_INIT;
            state_next = FLUSH;
          end else begin
            pc_next = pc_reg + PC_W'(1);
          end
        end
        FLUSH: begin
          // Wrong-path branches and flag writes are ignored here.
          pc_next  = pc_reg + PC_W'(1);
          cnt_next = cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) begin
            state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  // State register with synchronous active-low reset overriding stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= RUN;
      pc_reg    <= RESET_PC;
      flags_reg <= 4'b0000;
      cnt_reg   <= 4'd0;
      taken_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      flags_reg <= flags_next;
      cnt_reg   <= cnt_next;
      taken_reg <= taken_next;
    end
  end

  assign pc    = pc_reg;
  assign flags = flags_reg;
  assign taken = taken_reg;
  assign flush = (state_reg == FLUSH);
  assign busy  = (state_reg == FLUSH);

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: drives two branch_ctrl instances (flush lengths 1 and 3)
// with directed and random stimulus and compares every registered output
// against a behavioural model after each clock edge.
module tb_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, stall, flag_we, eq, neq, geq, l, br_valid;
  logic [2:0]  br_cond;
  logic [15:0] br_target;

  logic [15:0] pc_a, pc_b;
  logic [3:0]  flags_a, flags_b;
  logic        taken_a, taken_b, flush_a, flush_b, busy_a, busy_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  branch_ctrl #(.PC_W(16), .RESET_PC(16'h0000), .FLUSH_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flag_we(flag_we),
    .eq(eq), .neq(neq), .geq(geq), .l(l), .br_valid(br_valid),
    .br_cond(br_cond), .br_target(br_target), .pc(pc_a), .flags(flags_a),
    .taken(taken_a), .flush(flush_a), .busy(busy_a));

  branch_ctrl #(.PC_W(16), .RESET_PC(16'h0000), .FLUSH_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flag_we(flag_we),
    .eq(eq), .neq(neq), .geq(geq), .l(l), .br_valid(br_valid),
    .br_cond(br_cond), .br_target(br_target), .pc(pc_b), .flags(flags_b),
    .taken(taken_b), .flush(flush_b), .busy(busy_b));

  // Reference model: index 0 = flush length 1, index 1 = flush length 3.
  int          m_len [2] = '{1, 3};
  logic [15:0] m_pc    [2];
  logic [3:0]  m_flags [2];
  logic        m_taken [2];
  int          m_left  [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic cond_holds(input logic [2:0] c, input logic [3:0] f);
    logic is_eq;
    is_eq = f[3] && !f[2];
    case (c)
      3'd0: return 1'b0;
      3'd1: return 1'b1;
      3'd2: return is_eq;
      3'd3: return f[2];
      3'd4: return f[1];
      3'd5: return f[0];
      3'd6: return f[0] || is_eq;
      default: return f[1] && f[2];
    endcase
  endfunction

  task automatic model_edge();
    logic [3:0] incoming, use_f;
    incoming = {eq, neq, geq, l};
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_pc[k] = 16'h0000; m_flags[k] = 4'h0; m_taken[k] = 1'b0; m_left[k] = 0;
      end else if (stall) begin
        m_taken[k] = 1'b0;
      end else if (m_left[k] > 0) begin
        m_pc[k] = m_pc[k] + 16'd1; m_left[k] = m_left[k] - 1; m_taken[k] = 1'b0;
      end else begin
        use_f = flag_we ? incoming : m_flags[k];
        if (flag_we) m_flags[k] = incoming;
        if (br_valid && cond_holds(br_cond, use_f)) begin
          m_pc[k] = br_target; m_taken[k] = 1'b1; m_left[k] = m_len[k];
        end else begin
          m_pc[k] = m_pc[k] + 16'd1; m_taken[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("pc_f1",    32'(pc_a),    32'(m_pc[0]));
    check("flags_f1", 32'(flags_a), 32'(m_flags[0]));
    check("taken_f1", 32'(taken_a), 32'(m_taken[0]));
    check("flush_f1", 32'(flush_a), 32'(m_left[0] > 0));
    check("busy_f1",  32'(busy_a),  32'(m_left[0] > 0));
    check("pc_f3",    32'(pc_b),    32'(m_pc[1]));
    check("flags_f3", 32'(flags_b), 32'(m_flags[1]));
    check("taken_f3", 32'(taken_b), 32'(m_taken[1]));
    check("flush_f3", 32'(flush_b), 32'(m_left[1] > 0));
    check("busy_f3",  32'(busy_b),  32'(m_left[1] > 0));
  endtask

  task automatic drive(input logic r, input logic s, input logic fw, input logic [3:0] f,
                       input logic bv, input logic [2:0] c, input logic [15:0] t);
    rst_n = r; stall = s; flag_we = fw; {eq, neq, geq, l} = f;
    br_valid = bv; br_cond = c; br_target = t;
  endtask

  // One clock: update model from current inputs, then check at negedge.
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1, 0, 0, 4'h0, 0, 3'd0, 16'h0);
      step();
    end
  endtask

  int fl_cnt, tk_cnt;

  initial begin
    drive(0, 0, 0, 4'h0, 0, 3'd0, 16'h0);
    @(negedge clk);
    step();
    step();
    check("reset_pc", 32'(pc_a), 32'h0);
    check("reset_flags", 32'(flags_a), 32'h0);

    // Three free cycles after reset.
    idle(3);
    check("free_pc", 32'(pc_a), 32'h3);

    // Capture EQ, branch on EQ next cycle.
    drive(1, 0, 1, 4'b1000, 0, 3'd0, 16'h0); step();
    drive(1, 0, 0, 4'b0000, 1, 3'd2, 16'h0040); step();
    check("beq_pc", 32'(pc_a), 32'h0040);
    check("beq_taken", 32'(taken_a), 32'h1);
    idle(1);
    check("beq_next_pc", 32'(pc_a), 32'h0041);
    check("beq_flush_end", 32'(flush_a), 32'h0);
    idle(3);

    // Same-cycle bypass.
    drive(1, 0, 1, 4'b0110, 0, 3'd0, 16'h0); step();
    drive(1, 0, 1, 4'b0101, 1, 3'd5, 16'h1234); step();
    check("bypass_pc", 32'(pc_a), 32'h1234);
    check("bypass_flags", 32'(flags_a), 32'h5);
    idle(3);

    // Inconsistent flag vector.
    drive(1, 0, 1, 4'b1110, 0, 3'd0, 16'h0); step();
    drive(1, 0, 0, 4'b0000, 1, 3'd2, 16'h0500); step();
    check("incons_eq_not_taken", 32'(taken_a), 32'h0);
    drive(1, 0, 0, 4'b0000, 1, 3'd7, 16'h0600); step();
    check("incons_gt_taken", 32'(taken_a), 32'h1);
    idle(3);

    // Taken branch, then stall twice mid-flush with a branch held valid.
    fl_cnt = 0; tk_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1, (i == 2 || i == 3), 0, 4'h0, 1, 3'd1, 16'h2000);
      step();
      if (flush_b) fl_cnt++;
      if (taken_b) tk_cnt++;
    end
    check("stall_flush_len_f3", 32'(fl_cnt), 32'd5);
    check("stall_taken_cnt_f3", 32'(tk_cnt), 32'd1);
    idle(3);

    // PC wrap and reset during flush.
    drive(1, 0, 0, 4'h0, 1, 3'd1, 16'hFFFE); step();
    idle(1);
    check("pre_wrap_pc", 32'(pc_a), 32'hFFFF);
    idle(1);
    check("wrap_pc", 32'(pc_a), 32'h0000);
    idle(3);
    drive(1, 0, 0, 4'h0, 1, 3'd1, 16'h0777); step();
    drive(0, 1, 1, 4'hF, 1, 3'd1, 16'h0888); step();
    check("rst_flush", 32'(flush_b), 32'h0);
    check("rst_pc", 32'(pc_b), 32'h0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) >= 2),
            ($urandom_range(0, 99) < 20),
            ($urandom_range(0, 99) < 30),
            4'($urandom),
            ($urandom_range(0, 99) < 35),
            3'($urandom),
            ($urandom_range(0, 9) == 0) ? m_pc[0] : 16'($urandom));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
